pio_input_edge_irq: RTL and testbench
=====================================

// Module: pio_input_edge_irq
// PURPOSE
//  Avalon-MM slave input PIO: samples WIDTH external inputs (keys/switches) into clk domain,
//  detects edges, latches them in a sticky edge-capture register, raises a maskable IRQ.
//  Read-side counterpart of the LED output PIO; sits on the Nios II data master in the same system.
// PARAMETERS
//  WIDTH      18  number of input bits / data bus width
//  SYNC_STG   2   synchronizer flops per input bit (>=2)
//  EDGE_TYPE  0   0=rising, 1=falling, 2=any edge
//  RESET_IN   0   reset value of synchronizer/previous-sample flops (WIDTH bits, replicated)
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   2      word address: 0=DATA, 1=reserved, 2=IRQMASK, 3=EDGECAP
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   WIDTH  write data
//  in_port     in   WIDTH  asynchronous external inputs
//  readdata    out  WIDTH  read data, combinational from address (read latency 0)
//  irq         out  1      level interrupt, active high
// BEHAVIOUR
//  - Reset (async, reset_n=0): sync chain and prev sample <= RESET_IN; irq_mask <= 0;
//    edge_cap <= 0; hence irq=0, readdata reflects cleared regs.
//  - Sync: in_port through SYNC_STG flops -> sync_q; prev_q <= sync_q each clk.
//  - Edge: rise = sync_q & ~prev_q; fall = ~sync_q & prev_q; edge = per EDGE_TYPE.
//    Input change reaches DATA readback SYNC_STG cycles later, edge_cap bit one cycle after that.
//  - Write (chipselect & ~write_n): addr 2: irq_mask <= writedata. addr 3: write-1-to-clear,
//    edge_cap <= (edge_cap & ~writedata) | edge. addr 0/1: ignored.
//  - Otherwise edge_cap <= edge_cap | edge (sticky).
//  - Simultaneous clear and new edge on same bit: set wins, bit stays 1.
//  - Read mux: addr0 -> sync_q; addr1 -> 0; addr2 -> irq_mask; addr3 -> edge_cap.
//    Reads have no side effects; chipselect not needed for readdata.
//  - irq = |(edge_cap & irq_mask), registered: updates one clk after edge_cap/irq_mask change.
//  - Pulses shorter than one clk may be missed; no debounce (software's job).
//  - Reset mid-operation: all captured edges and mask lost; irq drops asynchronously with reset.
//  - Invalid EDGE_TYPE (>2): treated as rising.
// STRUCTURE
//  - Shared package/header: address constants PIO_ADDR_DATA=0, PIO_ADDR_IRQMASK=2,
//    PIO_ADDR_EDGECAP=3; EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
//  - Sub-module pio_sync_edge_detect (params WIDTH, SYNC_STG, EDGE_TYPE, RESET_IN):
//    synchronizer + prev sample + edge vector output. Top holds registers, read mux, irq.
// TESTING
//  1 Reset: hold reset_n=0, in_port=18'h3FFFF -> irq=0; read addr2, addr3 = 0.
//  2 Rising capture: EDGE_TYPE=0, in_port 0->18'h00005 -> addr0 reads 5 after 2 clks,
//    addr3 reads 5 after 3 clks; in_port back to 0 -> addr3 still 5, no new bits.
//  3 IRQ mask: mask=18'h00001, edge_cap=5 -> irq=1 one clk later; write addr3 1 -> edge_cap=4,
//    irq=0 next clk; write mask 4 -> irq=1.
//  4 Clear/edge collision: write addr3 18'h00002 in same cycle bit1 edge detected -> bit1 stays 1.
//  5 EDGE_TYPE=1 and 2: 1->0 transition captured for falling/any; 0->1 ignored for falling only.
//  6 Async reset mid-operation: edge_cap=3, mask=3, irq=1, pulse reset_n low 1 clk mid-cycle
//    -> irq=0 immediately, all regs 0; no spurious edge after release with in_port=RESET_IN.

Source files
------------

// File: rtl/pio_input_edge_irq_pkg.sv
// Shared constants for the edge-capturing input PIO: register map and edge-type encodings.
package pio_input_edge_irq_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_input_edge_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO (zero-latency reads).
interface pio_input_edge_irq_if #(
  parameter int WIDTH = 18
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_input_edge_irq_sync_edge_detect.sv
// Multi-flop input synchronizer plus previous-sample register and edge vector selection.
module pio_sync_edge_detect
  import pio_input_edge_irq_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int SYNC_STG  = 2,
  parameter int EDGE_TYPE = 0,
  parameter bit RESET_IN  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] edge_vec
);

  logic [SYNC_STG-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]               prev_q;
  logic [WIDTH-1:0]               rise;
  logic [WIDTH-1:0]               fall;

  // Synchronizer chain: entry at index 0, settled sample at the top index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {(SYNC_STG*WIDTH){RESET_IN}};
      prev_q <= {WIDTH{RESET_IN}};
    end else begin
      sync_r <= {sync_r[SYNC_STG-2:0], in_port};
      prev_q <= sync_q;
    end
  end

  assign sync_q = sync_r[SYNC_STG-1];
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;

  // Unknown edge-type encodings fall back to rising-edge detection
  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_vec = fall;
      EDGE_ANY:  edge_vec = rise | fall;
      default:   edge_vec = rise;
    endcase
  end

endmodule

// File: rtl/pio_input_edge_irq.sv
// Input PIO: synchronized DATA readback, sticky write-1-to-clear edge capture, masked level IRQ.
module pio_input_edge_irq
  import pio_input_edge_irq_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int SYNC_STG  = 2,
  parameter int EDGE_TYPE = 0,
  parameter bit RESET_IN  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_input_edge_irq_if.slave   bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic             wr_en;

  pio_sync_edge_detect #(
    .WIDTH     (WIDTH),
    .SYNC_STG  (SYNC_STG),
    .EDGE_TYPE (EDGE_TYPE),
    .RESET_IN  (RESET_IN)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync_q   (sync_q),
    .edge_vec (edge_det)
  );

  assign wr_en = bus.chipselect & ~bus.write_n;

  // Register stage: a new edge always wins over a same-cycle clear of that bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && bus.address == PIO_ADDR_IRQMASK)
        irq_mask <= bus.writedata;
      if (wr_en && bus.address == PIO_ADDR_EDGECAP)
        edge_cap <= (edge_cap & ~bus.writedata) | edge_det;
      else
        edge_cap <= edge_cap | edge_det;
      irq <= |(edge_cap & irq_mask);
    end
  end

  always_comb begin
    case (bus.address)
      PIO_ADDR_DATA:    bus.readdata = sync_q;
      PIO_ADDR_RSVD:    bus.readdata = '0;
      PIO_ADDR_IRQMASK: bus.readdata = irq_mask;
      default:          bus.readdata = edge_cap;
    endcase
  end

endmodule

// File: tb/tb_pio_input_edge_irq.sv
// Directed bench: three PIO instances (rising, falling, any edge) sharing clock, reset and inputs.
module tb_pio_input_edge_irq;
  localparam int W = 18;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] in_port;
  logic         irq0, irq1, irq2;
  int           checks;
  int           failures;

  pio_input_edge_irq_if #(.WIDTH(W)) bus0 ();
  pio_input_edge_irq_if #(.WIDTH(W)) bus1 ();
  pio_input_edge_irq_if #(.WIDTH(W)) bus2 ();

  pio_input_edge_irq #(.WIDTH(W), .SYNC_STG(2), .EDGE_TYPE(0), .RESET_IN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));
  pio_input_edge_irq #(.WIDTH(W), .SYNC_STG(2), .EDGE_TYPE(1), .RESET_IN(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq1));
  pio_input_edge_irq #(.WIDTH(W), .SYNC_STG(2), .EDGE_TYPE(2), .RESET_IN(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input int which, input logic [1:0] a, input logic [W-1:0] d);
    case (which)
      0: begin bus0.address = a; bus0.writedata = d; bus0.chipselect = 1'b1; bus0.write_n = 1'b0; end
      1: begin bus1.address = a; bus1.writedata = d; bus1.chipselect = 1'b1; bus1.write_n = 1'b0; end
      default: begin bus2.address = a; bus2.writedata = d; bus2.chipselect = 1'b1; bus2.write_n = 1'b0; end
    endcase
    tick(1);
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    in_port = 18'h3FFFF;
    #1 reset_n = 1'b0;
    tick(2);
    bus0.address = 2'd2; #1;
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq0); end
    checks++; if (bus0.readdata !== 18'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0", bus0.readdata); end
    bus0.address = 2'd3; #1;
    checks++; if (bus0.readdata !== 18'h0) begin failures++; $display("FAIL reset_edgecap got=%h exp=0", bus0.readdata); end
    bus0.address = 2'd0; #1;
    checks++; if (bus0.readdata !== 18'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus0.readdata); end
    in_port = 18'h0;
    tick(1);
    reset_n = 1'b1;
    tick(4);
    bus0.address = 2'd3; bus1.address = 2'd3; bus2.address = 2'd3; #1;
    checks++; if (bus0.readdata !== 18'h0) begin failures++; $display("FAIL release_cap0 got=%h exp=0", bus0.readdata); end
    checks++; if (bus1.readdata !== 18'h0) begin failures++; $display("FAIL release_cap1 got=%h exp=0", bus1.readdata); end
    checks++; if (bus2.readdata !== 18'h0) begin failures++; $display("FAIL release_cap2 got=%h exp=0", bus2.readdata); end
  endtask

  task automatic test_rising_capture;
    in_port = 18'h00005;
    tick(2);
    bus0.address = 2'd0; #1;
    checks++; if (bus0.readdata !== 18'h00005) begin failures++; $display("FAIL rise_data got=%h exp=5", bus0.readdata); end
    bus0.address = 2'd3; #1;
    checks++; if (bus0.readdata !== 18'h0) begin failures++; $display("FAIL rise_cap_early got=%h exp=0", bus0.readdata); end
    tick(1);
    checks++; if (bus0.readdata !== 18'h00005) begin failures++; $display("FAIL rise_cap got=%h exp=5", bus0.readdata); end
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL rise_irq_masked got=%b exp=0", irq0); end
    in_port = 18'h0;
    tick(4);
    checks++; if (bus0.readdata !== 18'h00005) begin failures++; $display("FAIL rise_sticky got=%h exp=5", bus0.readdata); end
    bus0.address = 2'd1; #1;
    checks++; if (bus0.readdata !== 18'h0) begin failures++; $display("FAIL reserved_read got=%h exp=0", bus0.readdata); end
  endtask

  task automatic test_irq_mask;
    bus_write(0, 2'd2, 18'h00001);
    bus0.address = 2'd2; #1;
    checks++; if (bus0.readdata !== 18'h00001) begin failures++; $display("FAIL mask_read got=%h exp=1", bus0.readdata); end
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_latency got=%b exp=0", irq0); end
    tick(1);
    checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq0); end
    bus_write(0, 2'd3, 18'h00001);
    bus0.address = 2'd3; #1;
    checks++; if (bus0.readdata !== 18'h00004) begin failures++; $display("FAIL w1c got=%h exp=4", bus0.readdata); end
    checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", irq0); end
    tick(1);
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq0); end
    bus_write(0, 2'd2, 18'h00004);
    tick(1);
    checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL irq_mask4 got=%b exp=1", irq0); end
    bus_write(0, 2'd0, 18'h3FFFF);
    bus0.address = 2'd3; #1;
    checks++; if (bus0.readdata !== 18'h00004) begin failures++; $display("FAIL data_write_ignored got=%h exp=4", bus0.readdata); end
  endtask

  task automatic test_clear_collision;
    in_port = 18'h00002;
    tick(2);
    bus_write(0, 2'd3, 18'h00006);
    bus0.address = 2'd3; #1;
    checks++; if (bus0.readdata !== 18'h00002) begin failures++; $display("FAIL collision got=%h exp=2", bus0.readdata); end
  endtask

  task automatic test_edge_types;
    bus_write(1, 2'd3, 18'h3FFFF);
    bus_write(2, 2'd3, 18'h3FFFF);
    bus1.address = 2'd3; bus2.address = 2'd3; #1;
    checks++; if (bus1.readdata !== 18'h0) begin failures++; $display("FAIL fall_cleared got=%h exp=0", bus1.readdata); end
    checks++; if (bus2.readdata !== 18'h0) begin failures++; $display("FAIL any_cleared got=%h exp=0", bus2.readdata); end
    in_port = 18'h0;
    tick(2);
    checks++; if (bus1.readdata !== 18'h0) begin failures++; $display("FAIL fall_early got=%h exp=0", bus1.readdata); end
    tick(1);
    bus0.address = 2'd3; #1;
    checks++; if (bus1.readdata !== 18'h00002) begin failures++; $display("FAIL fall_cap got=%h exp=2", bus1.readdata); end
    checks++; if (bus2.readdata !== 18'h00002) begin failures++; $display("FAIL any_fall_cap got=%h exp=2", bus2.readdata); end
    checks++; if (bus0.readdata !== 18'h00002) begin failures++; $display("FAIL rise_ignores_fall got=%h exp=2", bus0.readdata); end
    in_port = 18'h00008;
    tick(3);
    checks++; if (bus1.readdata !== 18'h00002) begin failures++; $display("FAIL fall_ignores_rise got=%h exp=2", bus1.readdata); end
    checks++; if (bus2.readdata !== 18'h0000A) begin failures++; $display("FAIL any_rise_cap got=%h exp=a", bus2.readdata); end
    checks++; if (bus0.readdata !== 18'h0000A) begin failures++; $display("FAIL rise_cap8 got=%h exp=a", bus0.readdata); end
  endtask

  task automatic test_async_reset;
    bus_write(0, 2'd3, 18'h3FFFF);
    in_port = 18'h0000B;
    tick(3);
    bus_write(0, 2'd2, 18'h00003);
    tick(1);
    bus0.address = 2'd3; #1;
    checks++; if (bus0.readdata !== 18'h00003) begin failures++; $display("FAIL pre_reset_cap got=%h exp=3", bus0.readdata); end
    checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b exp=1", irq0); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL async_irq got=%b exp=0", irq0); end
    checks++; if (bus0.readdata !== 18'h0) begin failures++; $display("FAIL async_cap got=%h exp=0", bus0.readdata); end
    bus0.address = 2'd2; #1;
    checks++; if (bus0.readdata !== 18'h0) begin failures++; $display("FAIL async_mask got=%h exp=0", bus0.readdata); end
    in_port = 18'h0;
    tick(1);
    #2 reset_n = 1'b1;
    tick(4);
    bus0.address = 2'd3; bus2.address = 2'd3; #1;
    checks++; if (bus0.readdata !== 18'h0) begin failures++; $display("FAIL post_reset_cap got=%h exp=0", bus0.readdata); end
    checks++; if (bus2.readdata !== 18'h0) begin failures++; $display("FAIL post_reset_any got=%h exp=0", bus2.readdata); end
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL post_reset_irq got=%b exp=0", irq0); end
    bus0.address = 2'd0; #1;
    checks++; if (bus0.readdata !== 18'h0) begin failures++; $display("FAIL post_reset_data got=%h exp=0", bus0.readdata); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
    bus1.address = 2'd0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
    bus2.address = 2'd0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
    test_reset();
    test_rising_capture();
    test_irq_mask();
    test_clear_collision();
    test_edge_types();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
